// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if: request/response handshake bundle between two requesters and the ALU arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0][2:0]       req_op;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [WIDTH-1:0]      resp_out;
  logic                  resp_zero;
  logic                  resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_out, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_out, resp_zero, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: round-robin sharing of one external combinational ALU by two requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  localparam logic [2:0] C_OP_BAD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_err;
  logic             w_winner;
  logic             w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    alu_in1        = '0;
    alu_in2        = '0;
    alu_ctrl       = 3'b000;
    // On contention the requester that did not win last time goes first.
    if (bus.req_valid == 2'b11) begin
      w_winner = ~r_last;
    end else begin
      w_winner = bus.req_valid[1];
    end
    case (r_state)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          w_accept                = 1'b1;
          bus.req_ready[w_winner] = rst_n;
          w_next                  = EXEC;
        end
      end
      EXEC: begin
        alu_in1  = r_a;
        alu_in2  = r_b;
        alu_ctrl = r_op;
        w_next   = RESP;
      end
      RESP: begin
        bus.resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready[r_owner]) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 3'b000;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.req_a[w_winner];
      r_b     <= bus.req_b[w_winner];
      r_op    <= bus.req_op[w_winner];
      r_owner <= w_winner;
      r_last  <= w_winner;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == EXEC) begin
      // The ALU result is undefined for the unsupported code, so it is never captured.
      if (r_op == C_OP_BAD) begin
        r_out  <= '0;
        r_zero <= (r_a == r_b);
        r_err  <= 1'b1;
      end else begin
        r_out  <= alu_out;
        r_zero <= alu_zero;
        r_err  <= 1'b0;
      end
    end
  end

  assign bus.resp_out  = r_out;
  assign bus.resp_zero = r_zero;
  assign bus.resp_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a behavioural ALU and arbiter model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] out;
    logic         zero;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  alu_arbiter_if #(.WIDTH(W)) bus();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  // External ALU; the unsupported code yields garbage that must never reach resp_out.
  always_comb begin
    alu_zero = (alu_in1 == alu_in2);
    case (alu_ctrl)
      3'd0:    alu_out = alu_in1 & alu_in2;
      3'd1:    alu_out = alu_in1 | alu_in2;
      3'd2:    alu_out = alu_in1 + alu_in2;
      3'd3:    alu_out = alu_in1 - alu_in2;
      3'd4:    alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      3'd5:    alu_out = alu_in1 << alu_in2[4:0];
      3'd6:    alu_out = alu_in1 >> alu_in2[4:0];
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  int           errors = 0;
  int           checks = 0;
  int           ncyc = 0;
  exp_t         sb_q[$];
  bit           grant_log[$];
  bit           busy = 1'b0;
  bit           last_grant = 1'b1;
  bit           exec_next = 1'b0;
  bit           held = 1'b0;
  exp_t         held_v;
  logic [W-1:0] ex_a;
  logic [W-1:0] ex_b;
  logic [2:0]   ex_op;
  logic [1:0]   acc_seen = 2'b00;
  int           acc_ncyc = 0;
  int           acc_ncyc_id[2];
  int           consume_ncyc = 0;
  bit           m_exec_now;
  bit           m_busy0;
  bit           m_w;
  logic [1:0]   m_rdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op);
    exp_t e;
    e.id   = id;
    e.zero = (a == b);
    e.err  = (op == 3'd7);
    case (op)
      3'd0:    e.out = a & b;
      3'd1:    e.out = a | b;
      3'd2:    e.out = a + b;
      3'd3:    e.out = a - b;
      3'd4:    e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    e.out = a << b[4:0];
      3'd6:    e.out = a >> b[4:0];
      default: e.out = '0;
    endcase
    return e;
  endfunction

  // Monitor: tracks the transaction at transaction level and checks every output each cycle.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      chk("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_zero, bus.resp_err,
                            alu_in1, alu_in2, alu_ctrl}, '0);
      sb_q.delete();
      busy       = 1'b0;
      last_grant = 1'b1;
      exec_next  = 1'b0;
      held       = 1'b0;
    end else begin
      m_exec_now = exec_next;
      exec_next  = 1'b0;
      m_busy0    = busy;
      chk("alu_drive", {alu_in1, alu_in2, alu_ctrl}, m_exec_now ? {ex_a, ex_b, ex_op} : '0);
      if (m_exec_now) chk("result_cleared_on_accept", {bus.resp_out, bus.resp_zero, bus.resp_err}, '0);
      if (!busy || m_exec_now) begin
        chk("resp_valid_quiet", bus.resp_valid, 2'b00);
      end else begin
        if (!held) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got response with empty queue at %0t", $time);
          end else begin
            held_v = sb_q.pop_front();
            held   = 1'b1;
            chk("resp_latency", ncyc - acc_ncyc, 2);
          end
        end
        if (held) begin
          chk("resp_valid", bus.resp_valid, held_v.id ? 2'b10 : 2'b01);
          chk("resp_data", {bus.resp_out, bus.resp_zero, bus.resp_err}, {held_v.out, held_v.zero, held_v.err});
          if (bus.resp_ready[held_v.id]) begin
            held         = 1'b0;
            busy         = 1'b0;
            consume_ncyc = ncyc;
          end
        end
      end
      m_w   = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
      m_rdy = (m_busy0 || bus.req_valid == 2'b00) ? 2'b00 : (m_w ? 2'b10 : 2'b01);
      chk("req_ready", bus.req_ready, m_rdy);
      if (m_rdy != 2'b00) begin
        sb_q.push_back(ref_model(m_w, bus.req_a[m_w], bus.req_b[m_w], bus.req_op[m_w]));
        ex_a             = bus.req_a[m_w];
        ex_b             = bus.req_b[m_w];
        ex_op            = bus.req_op[m_w];
        last_grant       = m_w;
        busy             = 1'b1;
        exec_next        = 1'b1;
        acc_seen[m_w]    = 1'b1;
        acc_ncyc         = ncyc;
        acc_ncyc_id[m_w] = ncyc;
        grant_log.push_back(m_w);
      end
    end
  end

  task automatic wait_acc(input logic [1:0] mask);
    int n = 0;
    while ((acc_seen & mask) == 2'b00 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if ((acc_seen & mask) == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept for mask %b, required one within 60 cycles", mask);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (busy || sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, required idle", busy, sb_q.size());
    end
  endtask

  task automatic drive(input bit i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_op[i]    = op;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic issue(input bit i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(posedge clk);
    #1;
    acc_seen = 2'b00;
    drive(i, a, b, op);
    wait_acc(i ? 2'b10 : 2'b01);
    #1;
    bus.req_valid[i] = 1'b0;
    bus.req_a[i]     = $urandom;
    bus.req_b[i]     = $urandom;
  endtask

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion, required finish within 200us");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int gstart;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 2'b11;

    // Contention from reset: requests already valid while reset is held.
    drive(1'b0, 32'd9, 32'd9, 3'd3);
    drive(1'b1, 32'd3, 32'd4, 3'd4);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gstart = grant_log.size();
    for (int k = 0; k < 3; k++) begin
      acc_seen = 2'b00;
      wait_acc(2'b11);
      #1;
    end
    bus.req_valid = 2'b00;
    if (grant_log.size() >= gstart + 3)
      chk("grant_order", {grant_log[gstart], grant_log[gstart+1], grant_log[gstart+2]}, 3'b010);
    wait_idle();

    issue(1'b0, 32'd5, 32'd7, 3'd2);
    wait_idle();

    // Back-pressure on requester 1 while requester 0 waits.
    @(posedge clk);
    #1 bus.resp_ready = 2'b01;
    issue(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'd1);
    acc_seen = 2'b00;
    drive(1'b0, 32'h1234, 32'h00FF, 3'd0);
    repeat (7) @(posedge clk);
    #1 bus.resp_ready = 2'b11;
    wait_acc(2'b01);
    #1 bus.req_valid = 2'b00;
    chk("backpressure_release", acc_ncyc_id[0], consume_ncyc + 1);
    wait_idle();

    issue(1'b0, 32'd3, 32'd3, 3'd7);
    issue(1'b0, 32'd1, 32'd4, 3'd5);
    wait_idle();

    // Reset while the ADD is in EXEC.
    issue(1'b0, 32'd1, 32'd1, 3'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_zero, bus.resp_err,
                                   alu_in1, alu_in2, alu_ctrl}, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("no_resp_after_reset", bus.resp_valid, 2'b00);
    gstart   = grant_log.size();
    acc_seen = 2'b00;
    drive(1'b0, 32'd1, 32'd1, 3'd2);
    drive(1'b1, 32'd8, 32'd2, 3'd6);
    wait_acc(2'b11);
    #1 bus.req_valid = 2'b00;
    if (grant_log.size() > gstart) chk("reset_favours_req0", grant_log[gstart], 1'b0);
    wait_idle();

    // Randomized traffic: requests held until accepted, random response back-pressure.
    acc_seen = 2'b00;
    for (int t = 0; t < 800; t++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc_seen[i] || !bus.req_valid[i]) begin
          acc_seen[i]      = 1'b0;
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_a[i]     = $urandom;
          bus.req_b[i]     = ($urandom_range(0, 3) == 0) ? bus.req_a[i] : $urandom;
          bus.req_op[i]    = 3'($urandom_range(0, 7));
        end
      end
      bus.resp_ready = 2'($urandom_range(0, 3));
    end
    #1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b11;
    wait_idle();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
